// File: rtl/rv_fetch_decode_q_if.sv
// Fetch/decode stage bus: instruction-memory handshake, EX redirect/stall inputs,
// and the decode bundle plus exception report consumed by the execute stage.
interface rv_fetch_decode_q_if;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [4:0]  ex_src1_sel;
    logic [4:0]  ex_src2_sel;
    logic [4:0]  ex_dst_sel;
    logic [2:0]  ex_alu_op;
    logic        ex_subtype;
    logic [9:0]  ex_ctrl;
    logic        exception;
    logic [1:0]  exc_cause;
    logic [31:0] exc_pc;

    modport master (
        output imem_ready, imem_addr,
        input  imem_valid, imem_rdata,
        input  redirect_valid, redirect_pc, stall,
        output ex_valid, ex_pc, ex_imm, ex_src1_sel, ex_src2_sel, ex_dst_sel,
        output ex_alu_op, ex_subtype, ex_ctrl,
        output exception, exc_cause, exc_pc
    );

    modport slave (
        input  imem_ready, imem_addr,
        output imem_valid, imem_rdata,
        output redirect_valid, redirect_pc, stall,
        input  ex_valid, ex_pc, ex_imm, ex_src1_sel, ex_src2_sel, ex_dst_sel,
        input  ex_alu_op, ex_subtype, ex_ctrl,
        input  exception, exc_cause, exc_pc
    );
endinterface

// File: rtl/rv_fetch_decode_q.sv
// RV32I fetch/decode stage: prefetch FIFO fed from instruction RAM, registered
// decode bundle to EX, EX redirect/flush, stall, and sticky exception reporting.
module rv_fetch_decode_q #(
    parameter logic [31:0] RESETVEC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          CNTW     = $clog2(DEPTH) + 1
) (
    input logic                clk,
    input logic                resetb,
    rv_fetch_decode_q_if.master bus
);

    localparam int PTRW = $clog2(DEPTH);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;
    localparam logic [6:0] OP_ARITHR = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [31:0]     buf_pc_q [DEPTH];
    logic [31:0]     buf_pc_d [DEPTH];
    logic [31:0]     buf_inst_q [DEPTH];
    logic [31:0]     buf_inst_d [DEPTH];

    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_pc_q, ex_pc_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic [4:0]  ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d, ex_dst_q, ex_dst_d;
    logic [2:0]  ex_alu_op_q, ex_alu_op_d;
    logic        ex_subtype_q, ex_subtype_d;
    logic [9:0]  ex_ctrl_q, ex_ctrl_d;
    logic        exception_q, exception_d;
    logic [1:0]  exc_cause_q, exc_cause_d;
    logic [31:0] exc_pc_q, exc_pc_d;

    logic        fetch_ready, accept, do_pop, do_push, illegal_pop;
    logic [31:0] head_inst, head_pc, dec_imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic        is_arithi, is_arithr, is_fence, is_system, is_legal, is_csr;
    logic [9:0]  dec_ctrl;

    assign head_inst = buf_inst_q[rd_ptr_q];
    assign head_pc   = buf_pc_q[rd_ptr_q];
    assign opcode    = head_inst[6:0];
    assign funct3    = head_inst[14:12];

    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_arithi = (opcode == OP_ARITHI);
    assign is_arithr = (opcode == OP_ARITHR);
    assign is_fence  = (opcode == OP_FENCE);
    assign is_system = (opcode == OP_SYSTEM);
    assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                       is_store | is_arithi | is_arithr | is_fence | is_system;
    // ECALL/EBREAK (imm12 0/1) are plain SYSTEM ops, everything else is a CSR access
    assign is_csr    = is_system && (head_inst[31:20] > 12'd1);
    assign dec_ctrl  = {is_jalr | is_load | is_arithi, is_store, is_load,
                        is_arithi | is_arithr, is_csr, is_lui, is_auipc,
                        is_jal, is_jalr, is_branch};

    always_comb begin
        dec_imm = 32'h0;
        if (is_lui || is_auipc) begin
            dec_imm = {head_inst[31:12], 12'h000};
        end else if (is_jal) begin
            dec_imm = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                       head_inst[20], head_inst[30:21], 1'b0};
        end else if (is_jalr || is_load) begin
            dec_imm = {{20{head_inst[31]}}, head_inst[31:20]};
        end else if (is_branch) begin
            dec_imm = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                       head_inst[30:25], head_inst[11:8], 1'b0};
        end else if (is_store) begin
            dec_imm = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
        end else if (is_arithi) begin
            if (funct3 == 3'b001 || funct3 == 3'b101)
                dec_imm = {27'h0, head_inst[24:20]};
            else
                dec_imm = {{20{head_inst[31]}}, head_inst[31:20]};
        end else if (is_system) begin
            dec_imm = {20'h0, head_inst[31:20]};
        end
    end

    // Redirect wins over everything: it blocks both the pop and any accepted response
    assign fetch_ready = !exception_q && (count_q < FULL) && (fetch_pc_q[1:0] == 2'b00);
    assign accept      = bus.imem_valid && fetch_ready;
    assign do_pop      = !bus.redirect_valid && !bus.stall && (count_q != '0);
    assign illegal_pop = do_pop && !is_legal;
    assign do_push     = accept && !bus.redirect_valid && !illegal_pop &&
                         ((count_q < FULL) || do_pop);

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        buf_pc_d     = buf_pc_q;
        buf_inst_d   = buf_inst_q;
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_imm_d     = ex_imm_q;
        ex_src1_d    = ex_src1_q;
        ex_src2_d    = ex_src2_q;
        ex_dst_d     = ex_dst_q;
        ex_alu_op_d  = ex_alu_op_q;
        ex_subtype_d = ex_subtype_q;
        ex_ctrl_d    = ex_ctrl_q;
        exception_d  = exception_q;
        exc_cause_d  = exc_cause_q;
        exc_pc_d     = exc_pc_q;

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            ex_valid_d = 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00 && !exception_q) begin
                exception_d = 1'b1;
                exc_cause_d = 2'd2;
                exc_pc_d    = bus.redirect_pc;
            end
        end else if (illegal_pop) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            ex_valid_d = 1'b0;
            if (!exception_q) begin
                exception_d = 1'b1;
                exc_cause_d = 2'd1;
                exc_pc_d    = head_pc;
            end
        end else begin
            if (do_push) begin
                buf_pc_d[wr_ptr_q]   = fetch_pc_q;
                buf_inst_d[wr_ptr_q] = bus.imem_rdata;
                wr_ptr_d             = wr_ptr_q + 1'b1;
                fetch_pc_d           = fetch_pc_q + 32'd4;
            end
            if (do_pop) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                ex_valid_d   = 1'b1;
                ex_pc_d      = head_pc;
                ex_imm_d     = dec_imm;
                ex_src1_d    = head_inst[19:15];
                ex_src2_d    = head_inst[24:20];
                ex_dst_d     = head_inst[11:7];
                ex_alu_op_d  = funct3;
                ex_subtype_d = head_inst[30] && !(is_arithi && funct3 == 3'b000);
                ex_ctrl_d    = dec_ctrl;
            end else if (!bus.stall) begin
                ex_valid_d = 1'b0;
            end
            count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            fetch_pc_q   <= RESETVEC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            buf_pc_q     <= '{default: '0};
            buf_inst_q   <= '{default: '0};
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= RESETVEC;
            ex_imm_q     <= '0;
            ex_src1_q    <= '0;
            ex_src2_q    <= '0;
            ex_dst_q     <= '0;
            ex_alu_op_q  <= '0;
            ex_subtype_q <= 1'b0;
            ex_ctrl_q    <= '0;
            exception_q  <= 1'b0;
            exc_cause_q  <= '0;
            exc_pc_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            buf_pc_q     <= buf_pc_d;
            buf_inst_q   <= buf_inst_d;
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_imm_q     <= ex_imm_d;
            ex_src1_q    <= ex_src1_d;
            ex_src2_q    <= ex_src2_d;
            ex_dst_q     <= ex_dst_d;
            ex_alu_op_q  <= ex_alu_op_d;
            ex_subtype_q <= ex_subtype_d;
            ex_ctrl_q    <= ex_ctrl_d;
            exception_q  <= exception_d;
            exc_cause_q  <= exc_cause_d;
            exc_pc_q     <= exc_pc_d;
        end
    end

    assign bus.imem_ready  = fetch_ready;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_src1_sel = ex_src1_q;
    assign bus.ex_src2_sel = ex_src2_q;
    assign bus.ex_dst_sel  = ex_dst_q;
    assign bus.ex_alu_op   = ex_alu_op_q;
    assign bus.ex_subtype  = ex_subtype_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.exception   = exception_q;
    assign bus.exc_cause   = exc_cause_q;
    assign bus.exc_pc      = exc_pc_q;

endmodule

// File: tb/tb_rv_fetch_decode_q.sv
// Directed bench for rv_fetch_decode_q: decode of a small program, fetch wait states,
// stall back-pressure, redirect flush, misaligned redirect, illegal opcode and reset.
module tb_rv_fetch_decode_q;

    logic clk;
    logic resetb;
    int   tests_run;
    int   tests_failed;

    logic [31:0] prog [8];
    logic [31:0] exp_imm [8];
    logic [9:0]  exp_ctrl [8];
    logic [31:0] bad_addr;

    rv_fetch_decode_q_if bus_if ();

    rv_fetch_decode_q #(
        .RESETVEC (32'h0000_0100),
        .DEPTH    (4)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: small program at 0x100, ADDI x1,x0,5 elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'h100;
        if (addr == bad_addr) return 32'hFFFF_FFFF;
        if (addr >= 32'h100 && off < 32'd32) return prog[off[4:2]];
        return 32'h0050_0093;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        bus_if.imem_rdata = mem_word(bus_if.imem_addr);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        resetb = 1'b1;
        bus_if.imem_rdata = mem_word(bus_if.imem_addr);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bad_addr     = 32'h0000_0001;

        prog[0] = 32'h0050_0093; exp_imm[0] = 32'h0000_0005; exp_ctrl[0] = 10'h240;
        prog[1] = 32'h1234_5137; exp_imm[1] = 32'h1234_5000; exp_ctrl[1] = 10'h010;
        prog[2] = 32'hFE31_2E23; exp_imm[2] = 32'hFFFF_FFFC; exp_ctrl[2] = 10'h100;
        prog[3] = 32'hFE20_8CE3; exp_imm[3] = 32'hFFFF_FFF8; exp_ctrl[3] = 10'h001;
        prog[4] = 32'h0100_00EF; exp_imm[4] = 32'h0000_0010; exp_ctrl[4] = 10'h004;
        prog[5] = 32'h4033_5293; exp_imm[5] = 32'h0000_0003; exp_ctrl[5] = 10'h240;
        prog[6] = 32'h3000_9073; exp_imm[6] = 32'h0000_0300; exp_ctrl[6] = 10'h020;
        prog[7] = 32'h0000_0073; exp_imm[7] = 32'h0000_0000; exp_ctrl[7] = 10'h000;

        resetb                = 1'b0;
        bus_if.imem_valid     = 1'b1;
        bus_if.imem_rdata     = 32'h0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        bus_if.stall          = 1'b0;
        #12;
        check_output("rst_addr",    bus_if.imem_addr, 32'h100);
        check_output("rst_ready",   32'(bus_if.imem_ready), 32'd1);
        check_output("rst_valid",   32'(bus_if.ex_valid), 32'd0);
        check_output("rst_ex_pc",   bus_if.ex_pc, 32'h100);
        check_output("rst_ex_imm",  bus_if.ex_imm, 32'h0);
        check_output("rst_ex_ctrl", 32'(bus_if.ex_ctrl), 32'h0);
        check_output("rst_exc",     32'(bus_if.exception), 32'd0);
        check_output("rst_cause",   32'(bus_if.exc_cause), 32'd0);
        check_output("rst_exc_pc",  bus_if.exc_pc, 32'h0);

        release_reset();
        check_output("start_addr", bus_if.imem_addr, 32'h100);
        tick();
        check_output("e1_addr",  bus_if.imem_addr, 32'h104);
        check_output("e1_valid", 32'(bus_if.ex_valid), 32'd0);

        for (int k = 0; k < 8; k++) begin
            tick();
            check_output($sformatf("dec%0d_valid", k), 32'(bus_if.ex_valid), 32'd1);
            check_output($sformatf("dec%0d_pc", k), bus_if.ex_pc, 32'h100 + 32'(4 * k));
            check_output($sformatf("dec%0d_addr", k), bus_if.imem_addr, 32'h108 + 32'(4 * k));
            check_output($sformatf("dec%0d_imm", k), bus_if.ex_imm, exp_imm[k]);
            check_output($sformatf("dec%0d_ctrl", k), 32'(bus_if.ex_ctrl), 32'(exp_ctrl[k]));
            if (k == 0) begin
                check_output("addi_rd",  32'(bus_if.ex_dst_sel), 32'd1);
                check_output("addi_rs1", 32'(bus_if.ex_src1_sel), 32'd0);
                check_output("addi_op",  32'(bus_if.ex_alu_op), 32'd0);
                check_output("addi_sub", 32'(bus_if.ex_subtype), 32'd0);
            end
            if (k == 2) begin
                check_output("sw_rs1", 32'(bus_if.ex_src1_sel), 32'd2);
                check_output("sw_rs2", 32'(bus_if.ex_src2_sel), 32'd3);
                check_output("sw_op",  32'(bus_if.ex_alu_op), 32'd2);
            end
            if (k == 5) begin
                check_output("srai_rd",  32'(bus_if.ex_dst_sel), 32'd5);
                check_output("srai_rs1", 32'(bus_if.ex_src1_sel), 32'd6);
                check_output("srai_op",  32'(bus_if.ex_alu_op), 32'd5);
                check_output("srai_sub", 32'(bus_if.ex_subtype), 32'd1);
            end
        end

        // Memory wait states at 0x124
        bus_if.imem_valid = 1'b0;
        tick();
        check_output("wait0_valid", 32'(bus_if.ex_valid), 32'd1);
        check_output("wait0_pc",    bus_if.ex_pc, 32'h120);
        check_output("wait0_addr",  bus_if.imem_addr, 32'h124);
        tick();
        check_output("wait1_valid", 32'(bus_if.ex_valid), 32'd0);
        check_output("wait1_addr",  bus_if.imem_addr, 32'h124);
        tick();
        check_output("wait2_valid", 32'(bus_if.ex_valid), 32'd0);
        check_output("wait2_addr",  bus_if.imem_addr, 32'h124);
        bus_if.imem_valid = 1'b1;
        tick();
        check_output("resume_addr",  bus_if.imem_addr, 32'h128);
        check_output("resume_valid", 32'(bus_if.ex_valid), 32'd0);
        tick();
        check_output("resume_pc",    bus_if.ex_pc, 32'h124);
        check_output("resume_v2",    32'(bus_if.ex_valid), 32'd1);
        check_output("resume_addr2", bus_if.imem_addr, 32'h12C);

        // Stall until the buffer fills and imem_ready drops
        bus_if.stall = 1'b1;
        for (int s = 0; s < 6; s++) begin
            tick();
            check_output($sformatf("stall%0d_pc", s), bus_if.ex_pc, 32'h124);
            check_output($sformatf("stall%0d_valid", s), 32'(bus_if.ex_valid), 32'd1);
            check_output($sformatf("stall%0d_ready", s), 32'(bus_if.imem_ready), (s < 2) ? 32'd1 : 32'd0);
            check_output($sformatf("stall%0d_addr", s), bus_if.imem_addr, (s < 3) ? 32'h130 + 32'(4 * s) : 32'h138);
        end
        bus_if.stall = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            check_output($sformatf("drain%0d_valid", j), 32'(bus_if.ex_valid), 32'd1);
            check_output($sformatf("drain%0d_pc", j), bus_if.ex_pc, 32'h128 + 32'(4 * j));
        end

        // Aligned redirect while a response at 0x14C is being accepted
        check_output("pre_redir_addr", bus_if.imem_addr, 32'h14C);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h200;
        tick();
        bus_if.redirect_valid = 1'b0;
        check_output("redir_valid", 32'(bus_if.ex_valid), 32'd0);
        check_output("redir_addr",  bus_if.imem_addr, 32'h200);
        tick();
        check_output("redir1_valid", 32'(bus_if.ex_valid), 32'd0);
        check_output("redir1_addr",  bus_if.imem_addr, 32'h204);
        tick();
        check_output("redir2_valid", 32'(bus_if.ex_valid), 32'd1);
        check_output("redir2_pc",    bus_if.ex_pc, 32'h200);

        // Misaligned redirect target
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h202;
        tick();
        bus_if.redirect_valid = 1'b0;
        check_output("mis_exc",    32'(bus_if.exception), 32'd1);
        check_output("mis_cause",  32'(bus_if.exc_cause), 32'd2);
        check_output("mis_exc_pc", bus_if.exc_pc, 32'h202);
        check_output("mis_ready",  32'(bus_if.imem_ready), 32'd0);
        check_output("mis_valid",  32'(bus_if.ex_valid), 32'd0);
        tick();
        tick();
        check_output("mis_ready2", 32'(bus_if.imem_ready), 32'd0);
        check_output("mis_valid2", 32'(bus_if.ex_valid), 32'd0);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h306;
        tick();
        bus_if.redirect_valid = 1'b0;
        check_output("sticky_cause", 32'(bus_if.exc_cause), 32'd2);
        check_output("sticky_pc",    bus_if.exc_pc, 32'h202);
        check_output("sticky_exc",   32'(bus_if.exception), 32'd1);

        // Asynchronous reset clears the sticky fault
        resetb = 1'b0;
        #2;
        check_output("rst2_exc",    32'(bus_if.exception), 32'd0);
        check_output("rst2_cause",  32'(bus_if.exc_cause), 32'd0);
        check_output("rst2_exc_pc", bus_if.exc_pc, 32'h0);
        check_output("rst2_addr",   bus_if.imem_addr, 32'h100);
        check_output("rst2_ready",  32'(bus_if.imem_ready), 32'd1);

        // Illegal word at 0x108
        bad_addr = 32'h108;
        release_reset();
        tick();
        tick();
        tick();
        check_output("ill_pre_valid", 32'(bus_if.ex_valid), 32'd1);
        check_output("ill_pre_pc",    bus_if.ex_pc, 32'h104);
        tick();
        check_output("ill_valid",  32'(bus_if.ex_valid), 32'd0);
        check_output("ill_exc",    32'(bus_if.exception), 32'd1);
        check_output("ill_cause",  32'(bus_if.exc_cause), 32'd1);
        check_output("ill_exc_pc", bus_if.exc_pc, 32'h108);
        check_output("ill_ready",  32'(bus_if.imem_ready), 32'd0);
        tick();
        check_output("ill_flush_valid", 32'(bus_if.ex_valid), 32'd0);

        // Reset mid-stream and restart from the reset vector
        resetb = 1'b0;
        #2;
        check_output("rst3_exc",   32'(bus_if.exception), 32'd0);
        check_output("rst3_valid", 32'(bus_if.ex_valid), 32'd0);
        check_output("rst3_addr",  bus_if.imem_addr, 32'h100);
        bad_addr = 32'h0000_0001;
        release_reset();
        tick();
        tick();
        check_output("restart_valid", 32'(bus_if.ex_valid), 32'd1);
        check_output("restart_pc",    bus_if.ex_pc, 32'h100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
